// File: rtl/mem_responder_pkg.sv
// Shared memory map and types for the cpu-side byte memory responder.
// The cpu and the responder both import this so they agree on one layout.
package mem_responder_pkg;

   localparam int unsigned DEF_ADDR_BITS       = 10;
   localparam int unsigned DEF_ROM_LIMIT       = 'h200;
   localparam logic [31:0] OP_STACK_TOP        = 32'h0000_03FF;
   localparam logic [31:0] CALL_STACK_TOP      = 32'h0000_02BF;
   localparam logic [31:0] FUNCTION_TABLE_BASE = 32'h0000_01C0;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StFetch,
      StReady
   } rd_state_e;

   function automatic logic addr_in_range(input logic [31:0] a, input int unsigned bits);
      if (bits >= 32) return 1'b1;
      return (a >> bits) == 32'd0;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// cpu <-> memory byte handshake: level read/write requests, level ready.
interface mem_responder_if;

   logic [31:0] addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        memory_read_en;
   logic        memory_write_en;
   logic        memory_ready;

   modport master (
      output addr, data_in, memory_read_en, memory_write_en,
      input  data_out, memory_ready
   );

   modport slave (
      input  addr, data_in, memory_read_en, memory_write_en,
      output data_out, memory_ready
   );

endinterface

// File: rtl/mem_responder_byte_ram.sv
// Single-port-write, registered-read byte array with no reset.
// A write and a read to the same address in one cycle returns the new byte.
module mem_responder_byte_ram #(
   parameter int unsigned ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [7:0]           wdata,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [7:0]           rdata
);

   logic [7:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
   end

endmodule

// File: rtl/mem_responder.sv
// Byte memory responder: cpu read/write port plus a write-only loader port,
// with ROM write protection, a fixed-latency read FSM and a sticky fault flag.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_BITS    = DEF_ADDR_BITS,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned ROM_LIMIT    = DEF_ROM_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_access,
   mem_responder_if.slave        bus,
   input  logic [31:0]           ld_addr,
   input  logic [7:0]            ld_data,
   input  logic                  ld_we,
   output logic                  fault
);

   localparam int unsigned CntW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(READ_LATENCY - 1);

   rd_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     req_addr_q, req_addr_d;
   logic            oor_q, oor_d;
   logic            fault_q;

   logic        cpu_wr, ld_wr, cpu_rd;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_in_range, rom_hit, ram_we, wr_fault;
   logic        ram_re, rd_oor, rd_fault, addr_changed;
   logic [7:0]  ram_rdata;

   assign cpu_wr  = mem_access & bus.memory_write_en;
   assign ld_wr   = ~mem_access & ld_we;
   // A concurrent write takes priority and parks the read FSM in idle.
   assign cpu_rd  = mem_access & bus.memory_read_en & ~bus.memory_write_en;
   assign wr_addr = mem_access ? bus.addr : ld_addr;
   assign wr_data = mem_access ? bus.data_in : ld_data;

   assign wr_in_range = addr_in_range(wr_addr, ADDR_BITS);
   assign rom_hit     = cpu_wr & (bus.addr < ROM_LIMIT);
   assign ram_we      = (cpu_wr | ld_wr) & wr_in_range & ~rom_hit;
   assign wr_fault    = (cpu_wr | ld_wr) & (~wr_in_range | rom_hit);

   assign rd_oor       = ~addr_in_range(req_addr_q, ADDR_BITS);
   assign addr_changed = bus.addr != req_addr_q;

   mem_responder_byte_ram #(
      .ADDR_BITS(ADDR_BITS)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(wr_addr[ADDR_BITS-1:0]),
      .wdata(wr_data),
      .re   (ram_re),
      .raddr(req_addr_q[ADDR_BITS-1:0]),
      .rdata(ram_rdata)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_addr_d = req_addr_q;
      oor_d      = oor_q;
      ram_re     = 1'b0;
      rd_fault   = 1'b0;
      if (!cpu_rd) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               req_addr_d = bus.addr;
               cnt_d      = CntLoad;
               state_d    = StWait;
            end
            default: begin
               // Any address change while requesting restarts the full latency.
               if (addr_changed) begin
                  req_addr_d = bus.addr;
                  cnt_d      = CntLoad;
                  state_d    = StWait;
               end else if (state_q == StWait) begin
                  if (cnt_q == '0) state_d = StFetch;
                  else             cnt_d   = cnt_q - 1'b1;
               end else if (state_q == StFetch) begin
                  ram_re   = 1'b1;
                  oor_d    = rd_oor;
                  rd_fault = rd_oor;
                  state_d  = StReady;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         req_addr_q <= '0;
         oor_q      <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_addr_q <= req_addr_d;
         oor_q      <= oor_d;
         fault_q    <= fault_q | wr_fault | rd_fault;
      end
   end

   assign bus.memory_ready = (state_q == StReady);
   assign bus.data_out     = (bus.memory_ready && !oor_q) ? ram_rdata : 8'h00;
   assign fault            = fault_q;

endmodule
